mar: RTL and testbench

- Memory Address Register for the SAP-1 datapath.
- Captures the low nibble of the W bus when load is asserted (active-low) on a rising clock edge.
- Drives the captured value continuously to the program ROM address input.
- Sits between the W bus and the 16-word ROM.

---
 rtl/sap_pkg.sv | 17 +
 rtl/sap_reg.sv | 39 +++
 rtl/mar.sv | 72 +++++++
 tb/tb_mar.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the SAP-1 datapath blocks (MAR, program counter, ROM).
//
// Contents:
//   ADDR_W_DEFAULT - default address width of the 16-word program ROM
//   addr_t         - 4-bit address type passed between PC, MAR and ROM
// -----------------------------------------------------------------------------
package sap_pkg;

    // The SAP-1 program ROM has 16 words, so every address in the
    // machine is one nibble wide.
    localparam int ADDR_W_DEFAULT = 4;

    typedef logic [3:0] addr_t;

endpackage : sap_pkg

// File: rtl/sap_reg.sv
// -----------------------------------------------------------------------------
// sap_reg
// Generic width-parameterised register used throughout the SAP-1 datapath.
// It has an asynchronous active-high clear and an active-low load enable.
//
// Parameters:
//   WIDTH     - register width in bits
//   CLR_VALUE - value forced into the register while clr is high
//
// Ports:
//   clk      (in)          rising-edge clock
//   clr      (in)          asynchronous active-high clear
//   load_bar (in)          active-low load enable, sampled on the rising edge
//   d        (in, WIDTH)   data captured when load_bar is low
//   q        (out, WIDTH)  registered value
// -----------------------------------------------------------------------------
module sap_reg #(
    parameter int                WIDTH     = 4,
    parameter logic [WIDTH-1:0]  CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_bar,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage element. The clear is in the sensitivity list so it takes
    // effect immediately, and it has priority over a load on the same edge.
    // When load_bar is high the register simply keeps its contents.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= CLR_VALUE;
        end else if (!load_bar) begin
            q <= d;
        end
    end

endmodule : sap_reg

// File: rtl/mar.sv
// -----------------------------------------------------------------------------
// mar
// Memory Address Register of the SAP-1. Captures the low nibble of the W bus
// on a rising CLK edge while Lm_bar is low and drives it to the program ROM.
//
// Optional feature (macro MAR_PROG_MODE_EN):
//   Adds the manual program-mode switches. With prog_mode high the ROM is
//   addressed directly from prog_addr; the register keeps working underneath.
//
// Parameters:
//   ADDR_W     - address width (default 4, a 16-word ROM)
//   RESET_ADDR - value loaded by CLR
//
// Ports:
//   CLK          (in)            system clock, rising edge
//   CLR          (in)            asynchronous active-high reset
//   W_low_nibble (in, ADDR_W)    low nibble of the W bus, the address source
//   Lm_bar       (in)            active-low load enable
//   prog_mode    (in)            [MAR_PROG_MODE_EN only] select manual address
//   prog_addr    (in, ADDR_W)    [MAR_PROG_MODE_EN only] manual address
//   ROM_address  (out, ADDR_W)   address presented to the program ROM
// -----------------------------------------------------------------------------
module mar
    import sap_pkg::*;
#(
    parameter int                 ADDR_W     = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] W_low_nibble,
    input  logic              Lm_bar,
`ifdef MAR_PROG_MODE_EN
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] prog_addr,
`endif
    output logic [ADDR_W-1:0] ROM_address
);

    logic [ADDR_W-1:0] addr_q;

    // The only state in this block: one register clocked from the W bus.
    sap_reg #(
        .WIDTH     (ADDR_W),
        .CLR_VALUE (RESET_ADDR)
    ) u_addr_reg (
        .clk      (CLK),
        .clr      (CLR),
        .load_bar (Lm_bar),
        .d        (W_low_nibble),
        .q        (addr_q)
    );

`ifdef MAR_PROG_MODE_EN
    // In program mode the operator's switches address the ROM directly so
    // memory can be inspected and written by hand; the register still
    // tracks loads so normal operation resumes where it left off.
    assign ROM_address = prog_mode ? prog_addr : addr_q;
`else
    // The ROM sees the register only, so W bus glitches between edges
    // never reach the address lines.
    assign ROM_address = addr_q;
`endif

`ifndef SYNTHESIS
    // An unknown load enable would make the register contents ambiguous;
    // flag it at every edge outside reset.
    assert property (@(posedge CLK) disable iff (CLR) !$isunknown(Lm_bar))
        else $error("mar: Lm_bar is X/Z at a rising CLK edge");
`endif

endmodule : mar

// File: tb/tb_mar.sv
// -----------------------------------------------------------------------------
// tb_mar
// Self-checking bench for the SAP-1 memory address register. A reference
// model of the address register pushes the expected ROM address into a
// scoreboard queue whenever stimulus is applied; the value is popped and
// compared once the DUT output is sampled.
// Define MAR_PROG_MODE_EN for both bench and RTL to cover program mode.
// -----------------------------------------------------------------------------
module tb_mar;
    import sap_pkg::*;

    localparam int ADDR_W = ADDR_W_DEFAULT;

    logic  clk;
    logic  clr;
    logic  lm_bar;
    addr_t w_low;
    addr_t rom_address;
`ifdef MAR_PROG_MODE_EN
    logic  prog_mode;
    addr_t prog_addr;
`endif

    int    num_compared   = 0;
    int    num_mismatched = 0;
    addr_t model_q;
    addr_t exp_queue[$];

    mar #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (4'h0)
    ) dut (
        .CLK          (clk),
        .CLR          (clr),
        .W_low_nibble (w_low),
        .Lm_bar       (lm_bar),
`ifdef MAR_PROG_MODE_EN
        .prog_mode    (prog_mode),
        .prog_addr    (prog_addr),
`endif
        .ROM_address  (rom_address)
    );

    // 10 ns clock; inputs change on the falling edge, outputs are sampled
    // 1 ns after the rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input addr_t observed, input addr_t expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Pop the oldest scoreboard entry and compare it with the DUT output now.
    task automatic popAndCheck(input string tag);
        addr_t expected;
        if (exp_queue.size() == 0) begin
            num_compared++;
            num_mismatched++;
            $display("[TB] FAIL %s: scoreboard empty, got %h", tag, rom_address);
        end else begin
            expected = exp_queue.pop_front();
            checkOutput(tag, rom_address, expected);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, predict the register
    // after the next rising edge, then sample and compare.
    task automatic applyStimulus(input logic lm, input addr_t w, input string tag);
        @(negedge clk);
        lm_bar = lm;
        w_low  = w;
        if (!lm) model_q = w;
        exp_queue.push_back(model_q);
        @(posedge clk);
        #1;
        popAndCheck(tag);
    endtask

    // Watchdog so a broken DUT or bench can never hang the run.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %h, expected finish", rom_address);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr    = 1'b1;
        lm_bar = 1'b0;
        w_low  = 4'hA;
        model_q = 4'h0;
`ifdef MAR_PROG_MODE_EN
        prog_mode = 1'b0;
        prog_addr = 4'h0;
`endif
        $display("[TB] starting tb_mar");

        // Reset held for 30 ns with a pending load: output must stay at 0.
        #1;
        exp_queue.push_back(4'h0);
        popAndCheck("reset_t1");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            exp_queue.push_back(4'h0);
            popAndCheck("reset_hold");
        end

        // Release at 30 ns (falling edge); the next rising edge loads 4'hA.
        @(negedge clk);
        clr = 1'b0;
        model_q = 4'hA;
        exp_queue.push_back(model_q);
        @(posedge clk);
        #1;
        popAndCheck("first_load_after_reset");

        // Load 3, then hold it while the bus sweeps every value.
        applyStimulus(1'b0, 4'h3, "load_3");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, addr_t'(i), "hold_sweep");
        end

        // Consecutive loads track the bus at every edge.
        applyStimulus(1'b0, 4'h5, "track_5");
        applyStimulus(1'b0, 4'h6, "track_6");
        applyStimulus(1'b0, 4'h7, "track_7");

        // Bus change between edges: no effect until the next edge samples it.
        @(negedge clk);
        lm_bar = 1'b0;
        w_low  = 4'h2;
        #2;
        w_low  = 4'h9;
        #1;
        exp_queue.push_back(model_q);
        popAndCheck("midcycle_no_effect");
        model_q = 4'h9;
        exp_queue.push_back(model_q);
        @(posedge clk);
        #1;
        popAndCheck("midcycle_load_9");

        // Full-range values with no wrap handling: F then 0 are two loads.
        applyStimulus(1'b0, 4'hF, "load_F");
        applyStimulus(1'b0, 4'h0, "load_0_after_F");

        // Asynchronous clear pulsed mid-cycle while holding 4'hC.
        applyStimulus(1'b0, 4'hC, "load_C");
        @(negedge clk);
        lm_bar = 1'b1;
        #1;
        clr = 1'b1;
        model_q = 4'h0;
        #1;
        exp_queue.push_back(model_q);
        popAndCheck("async_clear_during");
        clr = 1'b0;
        #1;
        exp_queue.push_back(model_q);
        popAndCheck("async_clear_before_edge");
        applyStimulus(1'b1, 4'hB, "hold_after_clear");

`ifdef MAR_PROG_MODE_EN
        // Program mode overrides the output without disturbing the register.
        applyStimulus(1'b0, 4'h4, "load_4");
        lm_bar    = 1'b1;
        prog_addr = 4'hE;
        prog_mode = 1'b1;
        #1;
        exp_queue.push_back(prog_addr);
        popAndCheck("prog_mode_on");
        prog_mode = 1'b0;
        #1;
        exp_queue.push_back(model_q);
        popAndCheck("prog_mode_off");
`endif

        if (exp_queue.size() != 0) begin
            num_compared++;
            num_mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_queue.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule : tb_mar
